// File: rtl/bp_pkg.sv
// Shared types and helpers for the bimodal branch predictor.
//   bp_update_t : one EX-stage branch resolution (pc, taken, mispredict)
//   sat_inc     : saturating increment up to a given maximum
//   sat_dec     : saturating decrement down to zero
package bp_pkg;

    // Widest PC carried in an update record; narrower PCs are zero-extended.
    localparam int BP_PC_W = 64;

    // Static rule: a target below the branch PC (a loop back-edge) predicts taken.
    localparam bit BTFN_BACKWARD_TAKEN = 1'b1;

    typedef struct packed {
        logic [BP_PC_W-1:0] pc;
        logic               taken;
        logic               mispredict;
    } bp_update_t;

    function automatic logic [3:0] sat_inc(input logic [3:0] ctr, input logic [3:0] max);
        return (ctr >= max) ? max : ctr + 4'd1;
    endfunction

    function automatic logic [3:0] sat_dec(input logic [3:0] ctr);
        return (ctr == 4'd0) ? 4'd0 : ctr - 4'd1;
    endfunction

endpackage

// File: rtl/bp_sat_counter_table.sv
// Direct-mapped table of saturating counters with per-entry valid bits.
//   clk, rst_n   : clock, synchronous active-low reset (clears every entry in one cycle)
//   rd_idx_i     : read index (from the IF-stage PC)
//   rd_taken_o   : MSB of the addressed counter
//   rd_vld_o     : addressed entry has been trained
//   wr_en_i      : apply one training update this cycle
//   wr_i         : update record (pc selects the entry, taken selects direction)
module bp_sat_counter_table
    import bp_pkg::*;
#(
    parameter int ENTRIES  = 64,
    parameter int CTR_BITS = 2,
    parameter int IDX_W    = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_taken_o,
    output logic             rd_vld_o,
    input  logic             wr_en_i,
    input  bp_update_t       wr_i
);

    localparam logic [CTR_BITS-1:0] WEAK_T  = CTR_BITS'(1) << (CTR_BITS - 1);
    localparam logic [CTR_BITS-1:0] WEAK_NT = WEAK_T - CTR_BITS'(1);
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

    logic [CTR_BITS-1:0] ctr_q [ENTRIES];
    logic [CTR_BITS-1:0] ctr_d [ENTRIES];
    logic [ENTRIES-1:0]  vld_q;
    logic [ENTRIES-1:0]  vld_d;
    logic [IDX_W-1:0]    wr_idx;
    logic                unused_wr;

    assign wr_idx    = wr_i.pc[IDX_W+1:2];
    assign unused_wr = ^{wr_i.pc, wr_i.mispredict};

    // Reads see the registered state only: a same-cycle update is not bypassed.
    assign rd_taken_o = ctr_q[rd_idx_i][CTR_BITS-1];
    assign rd_vld_o   = vld_q[rd_idx_i];

    always_comb begin
        ctr_d = ctr_q;
        vld_d = vld_q;
        if (wr_en_i) begin
            if (!vld_q[wr_idx]) begin
                // First sighting seeds the counter on the weak side of the outcome.
                vld_d[wr_idx] = 1'b1;
                ctr_d[wr_idx] = wr_i.taken ? WEAK_T : WEAK_NT;
            end else if (wr_i.taken) begin
                ctr_d[wr_idx] = CTR_BITS'(sat_inc(4'(ctr_q[wr_idx]), 4'(CTR_MAX)));
            end else begin
                ctr_d[wr_idx] = CTR_BITS'(sat_dec(4'(ctr_q[wr_idx])));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= WEAK_NT;
            end
            vld_q <= '0;
        end else begin
            ctr_q <= ctr_d;
            vld_q <= vld_d;
        end
    end

endmodule

// File: rtl/bimodal_branch_predictor.sv
// Bimodal branch predictor with static backward-taken/forward-not-taken fallback.
//   clk, rst_n          : clock, synchronous active-low reset
//   branch_instruction  : IF - current instruction is a conditional branch
//   current_pc/target_pc: IF - branch PC and computed target
//   branch_taken        : IF - predicted direction (combinational)
//   pred_from_table     : IF - 1 when a trained table entry supplied the prediction
//   update_*            : EX - one resolved branch per cycle
//   perf_branches       : saturating count of resolved branches
//   perf_mispredicts    : saturating count of mispredicted branches
module bimodal_branch_predictor
    import bp_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CTR_BITS    = 2,
    parameter int MODE        = 1,
    parameter int PERF_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              branch_instruction,
    input  logic [XLEN-1:0]   current_pc,
    input  logic [XLEN-1:0]   target_pc,
    output logic              branch_taken,
    output logic              pred_from_table,
    input  logic              update_valid,
    input  logic [XLEN-1:0]   update_pc,
    input  logic              update_taken,
    input  logic              update_mispredict,
    output logic [PERF_W-1:0] perf_branches,
    output logic [PERF_W-1:0] perf_mispredicts
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    bp_update_t        upd;
    logic              tbl_taken;
    logic              tbl_vld;
    logic              btfn_taken;
    logic [PERF_W-1:0] br_q, br_d;
    logic [PERF_W-1:0] mp_q, mp_d;

    assign upd.pc         = BP_PC_W'(update_pc);
    assign upd.taken      = update_taken;
    assign upd.mispredict = update_mispredict;

    bp_sat_counter_table #(
        .ENTRIES  (BHT_ENTRIES),
        .CTR_BITS (CTR_BITS),
        .IDX_W    (IDX_W)
    ) u_table (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_idx_i   (current_pc[IDX_W+1:2]),
        .rd_taken_o (tbl_taken),
        .rd_vld_o   (tbl_vld),
        .wr_en_i    (update_valid && (MODE == 1)),
        .wr_i       (upd)
    );

    assign btfn_taken = (target_pc < current_pc) ? BTFN_BACKWARD_TAKEN : !BTFN_BACKWARD_TAKEN;

    always_comb begin
        branch_taken    = 1'b0;
        pred_from_table = 1'b0;
        if (branch_instruction) begin
            if ((MODE == 1) && tbl_vld) begin
                branch_taken    = tbl_taken;
                pred_from_table = 1'b1;
            end else begin
                branch_taken    = btfn_taken;
            end
        end
    end

    // Counters stick at all-ones rather than wrapping.
    always_comb begin
        br_d = br_q;
        mp_d = mp_q;
        if (update_valid && (br_q != '1)) begin
            br_d = br_q + PERF_W'(1);
        end
        if (update_valid && update_mispredict && (mp_q != '1)) begin
            mp_d = mp_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            br_q <= '0;
            mp_q <= '0;
        end else begin
            br_q <= br_d;
            mp_q <= mp_d;
        end
    end

    assign perf_branches    = br_q;
    assign perf_mispredicts = mp_q;

endmodule

// File: tb/tb_bimodal_branch_predictor.sv
module tb_bimodal_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bi;
    logic [31:0] pc, tgt, upc;
    logic        uv, ut, um;

    logic        tk0, ft0, tk1, ft1, tk2, ft2;
    logic [31:0] pb0, pm0;
    logic [3:0]  pb1, pm1, pb2, pm2;

    always #5 clk = ~clk;

    // Three configurations share the stimulus:
    //   0: defaults (64 x 2-bit, dynamic, 32-bit perf)
    //   1: 16 x 3-bit, dynamic, 4-bit perf
    //   2: static BTFN only, 4-bit perf
    bimodal_branch_predictor dut0 (
        .clk(clk), .rst_n(rst_n), .branch_instruction(bi), .current_pc(pc), .target_pc(tgt),
        .branch_taken(tk0), .pred_from_table(ft0), .update_valid(uv), .update_pc(upc),
        .update_taken(ut), .update_mispredict(um), .perf_branches(pb0), .perf_mispredicts(pm0));

    bimodal_branch_predictor #(.BHT_ENTRIES(16), .CTR_BITS(3), .MODE(1), .PERF_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .branch_instruction(bi), .current_pc(pc), .target_pc(tgt),
        .branch_taken(tk1), .pred_from_table(ft1), .update_valid(uv), .update_pc(upc),
        .update_taken(ut), .update_mispredict(um), .perf_branches(pb1), .perf_mispredicts(pm1));

    bimodal_branch_predictor #(.MODE(0), .PERF_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .branch_instruction(bi), .current_pc(pc), .target_pc(tgt),
        .branch_taken(tk2), .pred_from_table(ft2), .update_valid(uv), .update_pc(upc),
        .update_taken(ut), .update_mispredict(um), .perf_branches(pb2), .perf_mispredicts(pm2));

    // ---------------- reference model ----------------
    int     ENT   [3] = '{64, 16, 64};
    int     BITS  [3] = '{2, 3, 2};
    bit     DYN   [3] = '{1'b1, 1'b1, 1'b0};
    longint PMAX  [3] = '{64'hFFFF_FFFF, 15, 15};

    int     m_ctr [3][64];
    bit     m_vld [3][64];
    longint m_br  [3];
    longint m_mp  [3];

    function automatic void model_reset();
        for (int d = 0; d < 3; d++) begin
            for (int e = 0; e < 64; e++) begin
                m_vld[d][e] = 1'b0;
                m_ctr[d][e] = (1 << (BITS[d] - 1)) - 1;
            end
            m_br[d] = 0;
            m_mp[d] = 0;
        end
    endfunction

    function automatic void model_update(logic [31:0] p, bit taken, bit mis);
        for (int d = 0; d < 3; d++) begin
            int idx;
            int half;
            int top;
            if (m_br[d] < PMAX[d]) m_br[d]++;
            if (mis && m_mp[d] < PMAX[d]) m_mp[d]++;
            if (DYN[d]) begin
                idx  = int'((p >> 2) % ENT[d]);
                half = 1 << (BITS[d] - 1);
                top  = (1 << BITS[d]) - 1;
                if (!m_vld[d][idx]) begin
                    m_vld[d][idx] = 1'b1;
                    m_ctr[d][idx] = taken ? half : half - 1;
                end else if (taken) begin
                    m_ctr[d][idx] = (m_ctr[d][idx] < top) ? m_ctr[d][idx] + 1 : top;
                end else begin
                    m_ctr[d][idx] = (m_ctr[d][idx] > 0) ? m_ctr[d][idx] - 1 : 0;
                end
            end
        end
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        string  name;
        bit     tk [3];
        bit     ft [3];
        longint br [3];
        longint mp [3];
    } exp_t;

    exp_t exp_q [$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic void check(string nm, longint act, longint want);
        n_tests++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, want);
        end
    endfunction

    function automatic exp_t predict(string nm);
        exp_t e;
        e.name = nm;
        for (int d = 0; d < 3; d++) begin
            int idx;
            idx = int'((pc >> 2) % ENT[d]);
            e.tk[d] = 1'b0;
            e.ft[d] = 1'b0;
            if (bi) begin
                if (DYN[d] && m_vld[d][idx]) begin
                    e.tk[d] = m_ctr[d][idx] >= (1 << (BITS[d] - 1));
                    e.ft[d] = 1'b1;
                end else begin
                    e.tk[d] = tgt < pc;
                end
            end
            e.br[d] = m_br[d];
            e.mp[d] = m_mp[d];
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.name, "_tk0"}, longint'(tk0), longint'(e.tk[0]));
            check({e.name, "_ft0"}, longint'(ft0), longint'(e.ft[0]));
            check({e.name, "_tk1"}, longint'(tk1), longint'(e.tk[1]));
            check({e.name, "_ft1"}, longint'(ft1), longint'(e.ft[1]));
            check({e.name, "_tk2"}, longint'(tk2), longint'(e.tk[2]));
            check({e.name, "_ft2"}, longint'(ft2), longint'(e.ft[2]));
            check({e.name, "_br0"}, longint'(pb0), e.br[0]);
            check({e.name, "_mp0"}, longint'(pm0), e.mp[0]);
            check({e.name, "_br1"}, longint'(pb1), e.br[1]);
            check({e.name, "_mp1"}, longint'(pm1), e.mp[1]);
            check({e.name, "_br2"}, longint'(pb2), e.br[2]);
            check({e.name, "_mp2"}, longint'(pm2), e.mp[2]);
        end
    end

    // ---------------- driver ----------------
    task automatic step(bit chk, string nm, bit b, logic [31:0] p, logic [31:0] t,
                        bit v, logic [31:0] up, bit tk, bit mis, bit rn);
        bi = b; pc = p; tgt = t; uv = v; upc = up; ut = tk; um = mis; rst_n = rn;
        if (chk) exp_q.push_back(predict(nm));
        @(posedge clk);
        #1;
        if (!rn) model_reset();
        else if (v) model_update(up, tk, mis);
    endtask

    task automatic pred(string nm, logic [31:0] p, logic [31:0] t);
        step(1, nm, 1, p, t, 0, 0, 0, 0, 1);
    endtask

    task automatic train(string nm, logic [31:0] p, logic [31:0] t, bit tk);
        step(1, nm, 1, p, t, 1, p, tk, 0, 1);
    endtask

    initial begin
        model_reset();
        step(0, "rst", 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, "rst", 0, 0, 0, 0, 0, 0, 0, 0);

        // T1 reset state and BTFN fallback
        pred("t1_back", 32'h100, 32'h0F0);
        pred("t1_fwd",  32'h100, 32'h120);
        step(1, "t1_nobr", 0, 32'h100, 32'h0F0, 0, 0, 0, 0, 1);

        // T2 counter training and saturation on pc 0x200
        pred("t2_pre", 32'h200, 32'h240);
        train("t2_t1", 32'h200, 32'h240, 1);
        pred("t2_after_t1", 32'h200, 32'h240);
        for (int i = 0; i < 3; i++) train("t2_t3", 32'h200, 32'h240, 1);
        pred("t2_after_t3", 32'h200, 32'h240);
        train("t2_n1", 32'h200, 32'h240, 0);
        pred("t2_after_n1", 32'h200, 32'h240);
        for (int i = 0; i < 2; i++) train("t2_n2", 32'h200, 32'h240, 0);
        pred("t2_after_n2", 32'h200, 32'h240);

        // T3 aliasing: 0x004 and 0x104 share idx 1 in the 64-entry table
        train("t3_train", 32'h004, 32'h040, 0);
        pred("t3_alias", 32'h104, 32'h100);

        // T4 same-cycle predict/update, no bypass
        train("t4_same", 32'h300, 32'h340, 1);
        pred("t4_next", 32'h300, 32'h340);

        // T5 mid-run reset drops the concurrent update
        step(1, "t5_rst", 1, 32'h200, 32'h240, 1, 32'h200, 1, 1, 0);
        pred("t5_after_200", 32'h200, 32'h240);
        pred("t5_after_004", 32'h104, 32'h100);

        // T6 perf counters saturate in the narrow configurations
        for (int i = 0; i < 20; i++)
            step(1, "t6_perf", 1, 32'h500, 32'h400, 1, $urandom_range(0, 1023), $urandom_range(0, 1), 1, 1);
        pred("t6_final", 32'h500, 32'h400);

        // Randomized traffic with a compact PC range to provoke aliasing
        step(0, "rst", 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            bit rn;
            rn = ($urandom_range(0, 299) != 0);
            step(1, "rand", $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1023), $urandom_range(0, 1023),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 1023),
                 $urandom_range(0, 1), $urandom_range(0, 3) == 0, rn);
        end

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
